// File: rtl/mux_n_1_stream_if.sv
`default_nettype none
// =============================================================================
// Module   : mux_n_1_stream_if
// Brief    : Stream bundle for mux_n_1_stream: N input channels and one output.
// Revision : 1.0 - initial release
// =============================================================================
interface mux_n_1_stream_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) ();
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_n_1_stream.sv
`default_nettype none
// =============================================================================
// Module   : mux_n_1_stream
// Brief    : N:1 valid/ready stream mux with a one-entry registered output.
//            STREAM_MUX_RR_EN adds a mode port and round-robin arbitration.
// Revision : 1.0 - initial release
// =============================================================================
module mux_n_1_stream #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SELW-1:0] sel,
`ifdef STREAM_MUX_RR_EN
    input  logic            mode,
`endif
    mux_n_1_stream_if.slave bus,
    output logic [15:0]     beat_count
);
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;
    logic [15:0]      r_beat_count;

    logic             w_load_en;
    logic             w_gnt_ok;
    logic [SELW-1:0]  w_gnt;
    logic [N-1:0]     w_in_ready;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_accept;

    assign w_load_en = !reset && (!r_out_valid || bus.out_ready);

`ifdef STREAM_MUX_RR_EN
    localparam logic [SELW-1:0] c_ptr_init = SELW'(N - 1);

    logic [SELW-1:0] r_ptr;
    logic [2*N-1:0]  w_rot;
    logic            w_rr_ok;
    logic [SELW-1:0] w_rr_gnt;

    // Rotate so bit 0 is the channel after r_ptr; the lowest set bit wins.
    always_comb begin
        w_rot    = {bus.in_valid, bus.in_valid} >> (int'(r_ptr) + 1);
        w_rr_ok  = 1'b0;
        w_rr_gnt = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_rr_ok  = 1'b1;
                w_rr_gnt = SELW'((int'(r_ptr) + 1 + j) % N);
            end
        end
    end
`endif

    always_comb begin
        w_gnt_ok = (int'(sel) < N);
        w_gnt    = sel;
`ifdef STREAM_MUX_RR_EN
        if (mode) begin
            w_gnt_ok = w_rr_ok;
            w_gnt    = w_rr_gnt;
        end
`endif
    end

    // An out-of-range select matches no channel, so nothing is granted.
    always_comb begin
        w_in_ready = '0;
        w_gnt_data = '0;
        for (int j = 0; j < N; j++) begin
            if (int'(w_gnt) == j) begin
                w_in_ready[j] = w_gnt_ok && w_load_en;
                w_gnt_data    = bus.in_data[j*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept = |(w_in_ready & bus.in_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_chan   <= '0;
            r_beat_count <= '0;
`ifdef STREAM_MUX_RR_EN
            r_ptr        <= c_ptr_init;
`endif
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_beat_count <= r_beat_count + 16'd1;
            end
            if (w_accept) begin
                r_out_data  <= w_gnt_data;
                r_out_chan  <= w_gnt;
                r_out_valid <= 1'b1;
`ifdef STREAM_MUX_RR_EN
                if (mode) begin
                    r_ptr <= w_gnt;
                end
`endif
            end else if (w_load_en) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;
    assign beat_count    = r_beat_count;
endmodule
`default_nettype wire
